simple_tx_sched: RTL and testbench
==================================

SIMPLE_TX_SCHED -- requirements
Module: simple_tx_sched

Interface
REQ-001 SHALL have parameter G_TYPE, default 16'h1234, frame type field transmitted MSB byte first.
REQ-002 SHALL have parameter G_MIN_SIZE, default 8, minimum accepted payload length in bytes.
REQ-003 SHALL have parameter G_IFG, default 2, minimum idle cycles between frames (txen_out low).
REQ-004 SHALL have ports:
  clk_in  in  1  single clock
  rst_in  in  1  asynchronous, active-high reset
  req_in  in  2  per-source frame request, level, held until granted or rejected
  len0_in / len1_in  in  8 each  payload length of source 0/1, valid while req_in[n]=1
  tdata0_in / tdata1_in  in  8 each  payload byte stream of source 0/1
  tvalid0_in / tvalid1_in  in  1 each  stream valid
  tlast0_in / tlast1_in  in  1 each  last payload byte marker
  tready0_out / tready1_out  out  1 each  stream ready
  grant_out  out  2  one-hot grant, high for whole frame
  reject_out  out  2  one-cycle pulse, request rejected
  txd_out  out  8  transmit byte
  txen_out  out  1  transmit byte valid
  stat_frame_cnt  out  16  frames completed
  stat_drop_cnt  out  16  frames rejected or aborted

Function
REQ-005 SHALL arbitrate only in IDLE with idle counter >= G_IFG; round-robin, last granted source lowest priority; after reset source 0 has priority.
REQ-006 On arbitration edge SHALL latch winner's len; if len < G_MIN_SIZE SHALL pulse reject_out[n] for one cycle, increment stat_drop_cnt, pass priority to the other source, restart idle count, not assert grant_out.
REQ-007 Otherwise SHALL assert grant_out[n] on that edge; states PRE(4), TYPE(2), SIZE(1), PAYLOAD(len), FCS(1), IFG, IDLE.
REQ-008 txd_out/txen_out SHALL be registered; first frame byte appears the cycle after grant_out rises; frame SHALL be len+8 consecutive txen_out-high cycles: 55 55 55 7F, G_TYPE[15:8], G_TYPE[7:0], len, payload bytes, FCS.
REQ-009 FCS SHALL be (G_TYPE[15:8] + G_TYPE[7:0] + len + sum of payload bytes) mod 256, accumulated in 8 bits, wrap ignored.
REQ-010 tready_out of granted source SHALL be high exactly in the len cycles preceding payload output, first coinciding with size byte on txd_out; a byte accepted on tvalid&tready at cycle c SHALL appear on txd_out at c+1; non-granted tready SHALL be 0.
REQ-011 tvalid low in any tready cycle (underrun) SHALL abort: txen_out low next cycle, no FCS, grant_out cleared, stat_drop_cnt+1, go to IFG.
REQ-012 tlast high on a byte other than byte len SHALL abort per REQ-011 after that byte; tlast absent on byte len SHALL be ignored.
REQ-013 On FCS completion stat_frame_cnt SHALL increment; grant_out SHALL clear with txen_out fall; txen_out SHALL stay low >= G_IFG cycles.
REQ-014 Counters SHALL wrap 16'hFFFF -> 0; req_in changes during a frame SHALL be ignored until next arbitration.
REQ-015 txd_out SHALL be 0 whenever txen_out is 0.

Reset
REQ-016 rst_in high SHALL immediately clear txd_out, txen_out, grant_out, reject_out, tready*_out, both counters, FSM to IDLE, idle counter satisfied, priority to source 0, including mid-frame.
REQ-017 First arbitration SHALL occur on the first clk_in edge after rst_in falls with req_in set.

Verification
REQ-018 req0, len0=0x0A, payload 11 22 33 44 55 66 77 88 99 AA -> txd 55 55 55 7F 12 34 0A 11..AA F7, txen 18 cycles, stat_frame_cnt=1.
REQ-019 req_in=2'b11 after reset, both len=8 -> source 0 frame, >=2 idle cycles, source 1 frame; repeat 2'b11 -> source 0 first.
REQ-020 req0 with len0=3 -> reject_out[0] one-cycle pulse, txen_out stays 0, stat_drop_cnt=1, then req1 len 8 granted.
REQ-021 tvalid0_in low on 5th payload byte -> txen_out low next cycle, no FCS byte, stat_drop_cnt+1, stat_frame_cnt unchanged.
REQ-022 rst_in pulse during PAYLOAD -> all outputs 0 asynchronously, counters 0; next len 8 frame transmits correctly.

Source files
------------

// File: rtl/simple_tx_sched.sv
// Two-source round-robin frame scheduler: wraps each granted payload stream as
// preamble, type, size, payload and an additive checksum, with a minimum idle gap.
module simple_tx_sched #(
  parameter logic [15:0] G_TYPE     = 16'h1234,
  parameter int unsigned G_MIN_SIZE = 8,
  parameter int unsigned G_IFG      = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  req_in,
  input  logic [7:0]  len0_in,
  input  logic [7:0]  len1_in,
  input  logic [7:0]  tdata0_in,
  input  logic [7:0]  tdata1_in,
  input  logic        tvalid0_in,
  input  logic        tvalid1_in,
  input  logic        tlast0_in,
  input  logic        tlast1_in,
  output logic        tready0_out,
  output logic        tready1_out,
  output logic [1:0]  grant_out,
  output logic [1:0]  reject_out,
  output logic [7:0]  txd_out,
  output logic        txen_out,
  output logic [15:0] stat_frame_cnt,
  output logic [15:0] stat_drop_cnt
);

  localparam int unsigned IDLE_W = 16;
  localparam logic [IDLE_W-1:0] IFG_TGT =
    IDLE_W'((G_IFG > 32'd65535) ? 32'd65535 : G_IFG);
  localparam logic [8:0] MIN_SZ =
    9'((G_MIN_SIZE > 32'd256) ? 32'd256 : G_MIN_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_TYPE, S_SIZE, S_PAYLOAD, S_FCS, S_END, S_ABORT, S_IFG
  } state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic              prio;
  logic              gsrc;
  logic [7:0]        len_q;
  logic [7:0]        cnt;
  logic [7:0]        fcs;

  logic              win;
  logic [7:0]        win_len;
  logic              too_short;
  logic              arb_ok;
  logic [7:0]        g_data;
  logic              g_valid;
  logic              g_last;
  logic              last_byte;
  logic [IDLE_W-1:0] idle_nxt;

  // Round robin: on a tie the source holding priority wins.
  assign win       = (req_in == 2'b11) ? prio : req_in[1];
  assign win_len   = win ? len1_in : len0_in;
  assign too_short = {1'b0, win_len} < MIN_SZ;
  assign arb_ok    = (state == S_IDLE) && (idle_cnt >= IFG_TGT) && (|req_in);

  assign g_data    = gsrc ? tdata1_in  : tdata0_in;
  assign g_valid   = gsrc ? tvalid1_in : tvalid0_in;
  assign g_last    = gsrc ? tlast1_in  : tlast0_in;
  assign last_byte = (cnt == 8'(len_q - 8'd1));
  assign idle_nxt  = idle_cnt + IDLE_W'(1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      idle_cnt       <= IFG_TGT;
      prio           <= 1'b0;
      gsrc           <= 1'b0;
      len_q          <= '0;
      cnt            <= '0;
      fcs            <= '0;
      tready0_out    <= 1'b0;
      tready1_out    <= 1'b0;
      grant_out      <= '0;
      reject_out     <= '0;
      txd_out        <= '0;
      txen_out       <= 1'b0;
      stat_frame_cnt <= '0;
      stat_drop_cnt  <= '0;
    end else begin
      reject_out <= '0;
      case (state)
        S_IDLE: begin
          if (idle_cnt < IFG_TGT) idle_cnt <= idle_nxt;
          if (arb_ok) begin
            len_q <= win_len;
            prio  <= ~win;
            if (too_short) begin
              reject_out    <= win ? 2'b10 : 2'b01;
              stat_drop_cnt <= stat_drop_cnt + 16'd1;
              idle_cnt      <= '0;
            end else begin
              grant_out <= win ? 2'b10 : 2'b01;
              gsrc      <= win;
              cnt       <= '0;
              state     <= S_PRE;
            end
          end
        end
        S_PRE: begin
          txen_out <= 1'b1;
          txd_out  <= (cnt == 8'd3) ? 8'h7F : 8'h55;
          cnt      <= cnt + 8'd1;
          if (cnt == 8'd3) begin
            cnt   <= '0;
            state <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (cnt == 8'd0) begin
            txd_out <= G_TYPE[15:8];
            fcs     <= G_TYPE[15:8];
            cnt     <= 8'd1;
          end else begin
            txd_out <= G_TYPE[7:0];
            fcs     <= fcs + G_TYPE[7:0];
            state   <= S_SIZE;
          end
        end
        // Ready opens together with the size byte so payload follows without a gap.
        S_SIZE: begin
          txd_out <= len_q;
          fcs     <= fcs + len_q;
          cnt     <= '0;
          if (len_q == 8'd0) begin
            state <= S_FCS;
          end else begin
            tready0_out <= ~gsrc;
            tready1_out <= gsrc;
            state       <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!g_valid) begin
            txen_out      <= 1'b0;
            txd_out       <= '0;
            tready0_out   <= 1'b0;
            tready1_out   <= 1'b0;
            grant_out     <= '0;
            stat_drop_cnt <= stat_drop_cnt + 16'd1;
            idle_cnt      <= '0;
            state         <= S_IFG;
          end else begin
            txd_out <= g_data;
            fcs     <= fcs + g_data;
            cnt     <= cnt + 8'd1;
            if (last_byte) begin
              tready0_out <= 1'b0;
              tready1_out <= 1'b0;
              state       <= S_FCS;
            end else if (g_last) begin
              tready0_out <= 1'b0;
              tready1_out <= 1'b0;
              state       <= S_ABORT;
            end
          end
        end
        S_FCS: begin
          txd_out <= fcs;
          state   <= S_END;
        end
        S_END: begin
          txen_out       <= 1'b0;
          txd_out        <= '0;
          grant_out      <= '0;
          stat_frame_cnt <= stat_frame_cnt + 16'd1;
          idle_cnt       <= '0;
          state          <= S_IFG;
        end
        // Early tlast: the marked byte was sent, the frame is dropped without FCS.
        S_ABORT: begin
          txen_out      <= 1'b0;
          txd_out       <= '0;
          grant_out     <= '0;
          stat_drop_cnt <= stat_drop_cnt + 16'd1;
          idle_cnt      <= '0;
          state         <= S_IFG;
        end
        S_IFG: begin
          idle_cnt <= idle_nxt;
          if (idle_nxt >= IFG_TGT) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_tx_sched.sv
// Directed bench for simple_tx_sched: table of single-source frames plus
// hand sequences for tie arbitration, underrun, early tlast and mid-frame reset.
module tb_simple_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  len0, len1, tdata0, tdata1;
  logic        tvalid0, tvalid1, tlast0, tlast1;
  logic        tready0, tready1, txen;
  logic [1:0]  grant, reject;
  logic [7:0]  txd;
  logic [15:0] frame_cnt, drop_cnt;

  simple_tx_sched dut (
    .clk_in(clk), .rst_in(rst), .req_in(req),
    .len0_in(len0), .len1_in(len1),
    .tdata0_in(tdata0), .tdata1_in(tdata1),
    .tvalid0_in(tvalid0), .tvalid1_in(tvalid1),
    .tlast0_in(tlast0), .tlast1_in(tlast1),
    .tready0_out(tready0), .tready1_out(tready1),
    .grant_out(grant), .reject_out(reject),
    .txd_out(txd), .txen_out(txen),
    .stat_frame_cnt(frame_cnt), .stat_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [7:0] len;
    logic [7:0] base;
    logic [7:0] stp;
    bit         use_last;
    bit         exp_rej;
    logic [7:0] exp_fcs;
    logic [15:0] exp_frames;
    logic [15:0] exp_drops;
  } vec_t;

  vec_t       vecs[6];
  int         checks = 0;
  int         passed = 0;
  int         idx[2], stall[2], lastix[2];
  logic [7:0] base[2], stp[2];
  logic [7:0] cap[$];
  logic [1:0] end_grant;
  logic [7:0] end_txd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pb(input int s, input int i);
    return 8'(int'(base[s]) + i * int'(stp[s]));
  endfunction

  task automatic drive();
    tdata0  = pb(0, idx[0]);
    tvalid0 = (idx[0] != stall[0]);
    tlast0  = (idx[0] == lastix[0]);
    tdata1  = pb(1, idx[1]);
    tvalid1 = (idx[1] != stall[1]);
    tlast1  = (idx[1] == lastix[1]);
  endtask

  // One clock: note handshakes mid-cycle, then advance streams just after the edge.
  task automatic step();
    bit a0, a1;
    @(negedge clk);
    a0 = tready0 && tvalid0;
    a1 = tready1 && tvalid1;
    @(posedge clk);
    #1;
    if (a0) idx[0]++;
    if (a1) idx[1]++;
    drive();
  endtask

  task automatic prep(input int s, input logic [7:0] l, input logic [7:0] b,
                      input logic [7:0] st, input int li, input int sv);
    base[s] = b; stp[s] = st; idx[s] = 0; lastix[s] = li; stall[s] = sv;
    if (s == 0) len0 = l; else len1 = l;
    drive();
  endtask

  task automatic wait_resp(input string tag, output int n);
    bit got;
    got = 0;
    n = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      n++;
      if (grant != 2'b00 || reject != 2'b00) got = 1;
    end
    if (!got) chk({tag, " response timeout"}, 32'd0, 32'd1);
  endtask

  // Called on the grant cycle; captures bytes until txen falls.
  task automatic collect(input string tag, input int s, output int tr_cnt,
                         output int tr_first, output int other);
    bit done;
    logic ts, to;
    cap.delete();
    tr_cnt = 0; tr_first = -1; other = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      ts = (s == 0) ? tready0 : tready1;
      to = (s == 0) ? tready1 : tready0;
      if (!txen) begin
        end_grant = grant;
        end_txd   = txd;
        done      = 1;
      end else begin
        if (ts) begin
          if (tr_first < 0) tr_first = cap.size();
          tr_cnt++;
        end
        if (to) other++;
        cap.push_back(txd);
      end
    end
    if (!done) chk({tag, " frame end timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int s, input logic [7:0] l,
                             input logic [7:0] exp_fcs, input int tr_cnt,
                             input int tr_first, input int other);
    logic [7:0] e[$];
    int bad;
    e = {8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34, l};
    for (int i = 0; i < int'(l); i++) e.push_back(pb(s, i));
    e.push_back(exp_fcs);
    bad = 0;
    for (int i = 0; i < e.size() && i < cap.size(); i++)
      if (cap[i] !== e[i]) bad++;
    chk({tag, " txen length"}, 32'(cap.size()), 32'(int'(l) + 8));
    chk({tag, " byte errors"}, 32'(bad), 32'd0);
    if (cap.size() > 0) chk({tag, " fcs"}, 32'(cap[cap.size()-1]), 32'(exp_fcs));
    chk({tag, " tready first at size byte"}, 32'(tr_first), 32'd6);
    chk({tag, " tready cycles"}, 32'(tr_cnt), 32'(l));
    chk({tag, " other tready"}, 32'(other), 32'd0);
    chk({tag, " grant drop with txen"}, 32'(end_grant), 32'd0);
    chk({tag, " txd idle zero"}, 32'(end_txd), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n, trc, trf, oth, gap;
    vecs[0] = '{0, 8'h0A, 8'h11, 8'h11, 1'b1, 1'b0, 8'hF7, 16'd1, 16'd0};
    vecs[1] = '{0, 8'h03, 8'h01, 8'h01, 1'b1, 1'b1, 8'h00, 16'd1, 16'd1};
    vecs[2] = '{1, 8'h08, 8'h01, 8'h01, 1'b0, 1'b0, 8'h72, 16'd2, 16'd1};
    vecs[3] = '{1, 8'h07, 8'h01, 8'h01, 1'b1, 1'b1, 8'h00, 16'd2, 16'd2};
    vecs[4] = '{1, 8'h09, 8'hF0, 8'h10, 1'b1, 1'b0, 8'hFF, 16'd3, 16'd2};
    vecs[5] = '{0, 8'hFF, 8'h00, 8'h01, 1'b1, 1'b0, 8'hC6, 16'd4, 16'd2};

    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
    for (int s = 0; s < 2; s++) begin
      idx[s] = 0; stall[s] = -1; lastix[s] = -1; base[s] = '0; stp[s] = '0;
    end
    drive();
    step(); step(); step();
    chk("reset outputs", 32'({txen, txd, grant, reject, tready0, tready1}), 32'd0);
    chk("reset counters", {frame_cnt, drop_cnt}, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      string tag;
      logic [1:0] oh;
      tag = $sformatf("vec%0d", v);
      oh  = (vecs[v].src == 0) ? 2'b01 : 2'b10;
      prep(vecs[v].src, vecs[v].len, vecs[v].base, vecs[v].stp,
           vecs[v].use_last ? int'(vecs[v].len) - 1 : -1, -1);
      req[vecs[v].src] = 1'b1;
      wait_resp(tag, n);
      req[vecs[v].src] = 1'b0;
      if (vecs[v].exp_rej) begin
        chk({tag, " reject"}, 32'(reject), 32'(oh));
        chk({tag, " no grant"}, 32'(grant), 32'd0);
        step();
        chk({tag, " reject width"}, 32'(reject), 32'd0);
        chk({tag, " txen quiet"}, 32'(txen), 32'd0);
      end else begin
        chk({tag, " grant"}, 32'(grant), 32'(oh));
        chk({tag, " txen on grant cycle"}, 32'(txen), 32'd0);
        collect(tag, vecs[v].src, trc, trf, oth);
        check_frame(tag, vecs[v].src, vecs[v].len, vecs[v].exp_fcs, trc, trf, oth);
      end
      chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(vecs[v].exp_frames));
      chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(vecs[v].exp_drops));
    end

    // Simultaneous requests after reset: source 0 first, then 1, then 0 again.
    do_reset();
    prep(0, 8'd8, 8'h01, 8'h01, 7, -1);
    prep(1, 8'd8, 8'h01, 8'h01, 7, -1);
    req = 2'b11;
    wait_resp("tie1", n);
    chk("tie1 grant", 32'(grant), 32'h1);
    req[0] = 1'b0;
    collect("tie1", 0, trc, trf, oth);
    check_frame("tie1", 0, 8'd8, 8'h72, trc, trf, oth);
    wait_resp("tie2", n);
    gap = n + 1;
    chk("tie2 grant", 32'(grant), 32'h2);
    chk("tie ifg >= 2", 32'(gap >= 2), 32'd1);
    req[1] = 1'b0;
    collect("tie2", 1, trc, trf, oth);
    check_frame("tie2", 1, 8'd8, 8'h72, trc, trf, oth);
    prep(0, 8'd8, 8'h01, 8'h01, 7, -1);
    prep(1, 8'd8, 8'h01, 8'h01, 7, -1);
    req = 2'b11;
    wait_resp("tie3", n);
    chk("tie3 grant", 32'(grant), 32'h1);
    req[0] = 1'b0;
    collect("tie3", 0, trc, trf, oth);
    wait_resp("tie4", n);
    req[1] = 1'b0;
    collect("tie4", 1, trc, trf, oth);
    chk("tie frame_cnt", 32'(frame_cnt), 32'd4);

    // Underrun on the fifth payload byte.
    prep(0, 8'h0A, 8'h11, 8'h11, 9, 4);
    req[0] = 1'b1;
    wait_resp("underrun", n);
    req[0] = 1'b0;
    collect("underrun", 0, trc, trf, oth);
    chk("underrun bytes", 32'(cap.size()), 32'd11);
    if (cap.size() == 11) chk("underrun last byte", 32'(cap[10]), 32'h44);
    chk("underrun grant cleared", 32'(end_grant), 32'd0);
    chk("underrun drop_cnt", 32'(drop_cnt), 32'd1);
    chk("underrun frame_cnt", 32'(frame_cnt), 32'd4);
    stall[0] = -1;

    // Early tlast on the third payload byte.
    prep(1, 8'h0A, 8'hA0, 8'h01, 2, -1);
    req[1] = 1'b1;
    wait_resp("tlast", n);
    req[1] = 1'b0;
    collect("tlast", 1, trc, trf, oth);
    chk("tlast bytes", 32'(cap.size()), 32'd10);
    if (cap.size() == 10) chk("tlast last byte", 32'(cap[9]), 32'hA2);
    chk("tlast drop_cnt", 32'(drop_cnt), 32'd2);
    chk("tlast frame_cnt", 32'(frame_cnt), 32'd4);

    // Asynchronous reset in the middle of the payload.
    prep(0, 8'h0A, 8'h11, 8'h11, 9, -1);
    req[0] = 1'b1;
    wait_resp("midrst", n);
    req[0] = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("midrst in payload", 32'(txen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst outputs async", 32'({txen, txd, grant, reject, tready0, tready1}), 32'd0);
    chk("midrst counters", {frame_cnt, drop_cnt}, 32'd0);
    step();
    step();
    rst = 1'b0;
    prep(0, 8'd8, 8'h01, 8'h01, 7, -1);
    req[0] = 1'b1;
    wait_resp("postrst", n);
    req[0] = 1'b0;
    chk("postrst grant", 32'(grant), 32'h1);
    collect("postrst", 0, trc, trf, oth);
    check_frame("postrst", 0, 8'd8, 8'h72, trc, trf, oth);
    chk("postrst frame_cnt", 32'(frame_cnt), 32'd1);
    chk("postrst drop_cnt", 32'(drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
